// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed hex display scanner with frame-aligned pending-word commit.
// Optional leading-zero blanking is compiled in with `define LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   blank_mask,
  output logic [3:0]        digit_code,
  output logic [NDIG-1:0]   an_n,
  output logic              frame_done
);

  localparam int MAXC = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [IW-1:0] LAST    = IW'(NDIG - 1);
  localparam logic [CW-1:0] G_LAST  = CW'(GUARD - 1);
  localparam logic [CW-1:0] D_LAST  = CW'(DIV - 1);

  logic [0:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic [4*NDIG-1:0] pend_q, pend_d;
  logic              pv_q, pv_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              fd_q, fd_d;
  logic [NDIG-1:0]   lz;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    unique case (state_q)
      ST_GUARD: begin
        if (cnt_q == G_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == D_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          if (idx_q == LAST) begin
            idx_d = '0;
            if (pv_q) begin
              disp_d = pend_q;
              pv_d   = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    // ready is low while pending, so this never collides with the commit
    if (load_valid && !pv_q) begin
      pend_d = load_data;
      pv_d   = 1'b1;
    end
  end

`ifdef LZ_BLANK_EN
  logic nz;
  always_comb begin
    lz = '0;
    nz = 1'b0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      nz    = nz | (disp_d[4*i +: 4] != 4'h0);
      lz[i] = ~nz;
    end
  end
`else
  always_comb begin
    lz = '0;
  end
`endif

  // outputs are registered from next state so they line up with state_q
  always_comb begin
    an_d = '1;
    if (state_d == ST_SHOW && !(blank_mask[idx_d] || lz[idx_d]))
      an_d[idx_d] = 1'b0;
    fd_d = (state_d == ST_SHOW) && (idx_d == LAST) && (cnt_d == D_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GUARD;
      idx_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      an_q    <= '1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign load_ready = ~pv_q;
  assign digit_code = disp_q[4*idx_q +: 4];
  assign an_n       = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NDIG=4, DIV=4, GUARD=1).
// Expected outputs come from a frame-arithmetic model of the scan.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int GUARD = 1;
  localparam int SL    = GUARD + DIV;
  localparam int FR    = NDIG * SL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  digit_code;
  logic [3:0]  an_n;
  logic        frame_done;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_mask (blank_mask),
    .digit_code (digit_code),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [3:0] code;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // model state
  int          m_t;
  logic [15:0] m_disp, m_pend;
  logic        m_pv;
  logic [3:0]  m_mask_prev;
  logic        m_acc;
  int          n_acc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, m_t, act, exp);
    end
  endtask

  function automatic logic lz_blank(input int d);
`ifdef LZ_BLANK_EN
    return (d != 0) && ((m_disp >> (4*d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_exp();
    exp_t e;
    int s, d, pos;
    s   = m_t % FR;
    d   = s / SL;
    pos = s % SL;
    e.code = m_disp[4*d +: 4];
    e.an   = 4'hF;
    if (pos >= GUARD && !(m_mask_prev[d] || lz_blank(d)))
      e.an[d] = 1'b0;
    e.fd  = (s == FR - 1);
    e.rdy = !m_pv;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
    m_mask_prev = '0;
  endtask

  // drive inputs for the current cycle, advance one edge, predict next cycle
  task automatic cycle(input logic lv, input logic [15:0] ld, input logic [3:0] bm);
    load_valid = lv;
    load_data  = ld;
    blank_mask = bm;
    @(posedge clk);
    m_acc = lv && !m_pv;
    if ((m_t % FR) == FR - 1 && m_pv) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end
    if (m_acc) begin
      m_pend = ld;
      m_pv   = 1'b1;
      n_acc++;
    end
    m_mask_prev = bm;
    m_t++;
    #1;
    push_exp();
  endtask

  task automatic idle(input int n, input logic [3:0] bm);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, bm);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    push_exp();
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("an_n", an_n, e.an);
      chk("digit_code", digit_code, e.code);
      chk("frame_done", frame_done, e.fd);
      chk("load_ready", load_ready, e.rdy);
    end
  end

  initial begin
    model_reset();
    n_acc = 0;
    #13;
    chk("rst_an_n", an_n, 4'hF);
    chk("rst_code", digit_code, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_fd", frame_done, 0);
    release_reset();

    // mid-frame load at cycle 7
    idle(7, 4'h0);
    cycle(1'b1, 16'h12AF, 4'h0);
    idle(35, 4'h0);

    // back-to-back loads held valid
    n_acc = 0;
    for (int i = 0; i < 100 && n_acc < 2; i++)
      cycle(1'b1, (n_acc == 0) ? 16'h1111 : 16'h2222, 4'h0);
    chk("b2b_accepts", n_acc, 2);
    idle(45, 4'h0);

    // live blank mask on digit 2
    idle(2 * FR, 4'b0100);

    // leading-zero patterns
    cycle(1'b1, 16'h0030, 4'h0);
    idle(2 * FR, 4'h0);
    cycle(1'b1, 16'h0000, 4'h0);
    idle(2 * FR, 4'h0);

    // reset mid-SHOW with a pending word
    cycle(1'b1, 16'hBEEF, 4'h0);
    while (!((m_t % SL) >= GUARD + 1 && (m_t % FR) < FR - SL && m_pv))
      idle(1, 4'h0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_an_n", an_n, 4'hF);
    chk("async_rst_ready", load_ready, 1);
    release_reset();
    idle(2 * FR, 4'h0);

    // randomized traffic
    begin
      logic [3:0] bm;
      bm = '0;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 29) == 0) bm = 4'($urandom_range(0, 15));
        cycle($urandom_range(0, 7) == 0, 16'($urandom), bm);
      end
    end
    idle(FR, 4'h0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
